// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: single-clock FIFO with registered read data, level count, runtime almost flags,
// synchronous flush and sticky error flags. Define SYNC_FIFO_FLEX_FWFT_EN for first-word-fall-through.
module sync_fifo_flex #(
   parameter int    DATA_WIDTH = 32,
   parameter int    ADDR_WIDTH = 4,
   parameter string RAM_STYLE  = "auto"
) (
   input  logic                  clk_i,
   input  logic                  a_rst_i,
   input  logic                  flush_i,
   input  logic                  wr_en_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic                  full_o,
   output logic                  almost_full_o,
   input  logic                  rd_en_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  valid_o,
   output logic                  empty_o,
   output logic                  almost_empty_o,
   input  logic [ADDR_WIDTH:0]   af_thresh_i,
   input  logic [ADDR_WIDTH:0]   ae_thresh_i,
   output logic [ADDR_WIDTH:0]   level_o,
   output logic                  overflow_o,
   output logic                  underflow_o
);

   localparam int                DEPTH     = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] LEVEL_MAX = DEPTH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] ONE       = (ADDR_WIDTH + 1)'(1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [ADDR_WIDTH:0]   wr_ptr_reg;
   logic [ADDR_WIDTH:0]   rd_ptr_reg;
   logic [ADDR_WIDTH:0]   level_reg;
   logic [DATA_WIDTH-1:0] data_reg;
   logic                  valid_reg;
   logic                  overflow_reg;
   logic                  underflow_reg;

   logic                  wr_ok;
   logic                  rd_ok;
   logic                  wr_err;
   logic                  rd_err;
   logic                  mem_wr;

   assign full_o         = (level_reg == LEVEL_MAX);
   assign almost_full_o  = (level_reg >= af_thresh_i);
   assign almost_empty_o = (level_reg <= ae_thresh_i);
   assign level_o        = level_reg;
   assign data_o         = data_reg;
   assign valid_o        = valid_reg;
   assign overflow_o     = overflow_reg;
   assign underflow_o    = underflow_reg;

   // Flush overrides both requests, so neither side can be accepted or flagged during it.
   assign wr_ok  = wr_en_i & ~full_o & ~flush_i;
   assign wr_err = wr_en_i &  full_o & ~flush_i;
   assign rd_err = rd_en_i &  empty_o & ~flush_i;

`ifdef SYNC_FIFO_FLEX_FWFT_EN
   logic mem_empty;
   logic load_ok;
   logic bypass;

   assign empty_o   = ~valid_reg;
   assign rd_ok     = rd_en_i & valid_reg & ~flush_i;
   assign mem_empty = (wr_ptr_reg == rd_ptr_reg);
   assign load_ok   = ~valid_reg | rd_ok;
   // A write that finds the output register free and memory empty goes straight to the output.
   assign bypass    = load_ok & mem_empty & wr_ok;
   assign mem_wr    = wr_ok & ~bypass;

   always_ff @(posedge clk_i or posedge a_rst_i) begin
      if (a_rst_i) begin
         rd_ptr_reg <= '0;
         data_reg   <= '0;
         valid_reg  <= 1'b0;
      end else if (flush_i) begin
         rd_ptr_reg <= '0;
         valid_reg  <= 1'b0;
      end else if (load_ok) begin
         if (!mem_empty) begin
            data_reg   <= mem[rd_ptr_reg[ADDR_WIDTH-1:0]];
            rd_ptr_reg <= rd_ptr_reg + ONE;
            valid_reg  <= 1'b1;
         end else if (wr_ok) begin
            data_reg  <= data_i;
            valid_reg <= 1'b1;
         end else begin
            valid_reg <= 1'b0;
         end
      end
   end
`else
   assign empty_o = (level_reg == '0);
   assign rd_ok   = rd_en_i & ~empty_o & ~flush_i;
   assign mem_wr  = wr_ok;

   always_ff @(posedge clk_i or posedge a_rst_i) begin
      if (a_rst_i) begin
         rd_ptr_reg <= '0;
         data_reg   <= '0;
         valid_reg  <= 1'b0;
      end else if (flush_i) begin
         rd_ptr_reg <= '0;
         valid_reg  <= 1'b0;
      end else begin
         valid_reg <= rd_ok;
         if (rd_ok) begin
            data_reg   <= mem[rd_ptr_reg[ADDR_WIDTH-1:0]];
            rd_ptr_reg <= rd_ptr_reg + ONE;
         end
      end
   end
`endif

   always_ff @(posedge clk_i) begin
      if (mem_wr) begin
         mem[wr_ptr_reg[ADDR_WIDTH-1:0]] <= data_i;
      end
   end

   always_ff @(posedge clk_i or posedge a_rst_i) begin
      if (a_rst_i) begin
         wr_ptr_reg    <= '0;
         level_reg     <= '0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else if (flush_i) begin
         wr_ptr_reg    <= '0;
         level_reg     <= '0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         if (mem_wr) begin
            wr_ptr_reg <= wr_ptr_reg + ONE;
         end
         case ({wr_ok, rd_ok})
            2'b10:   level_reg <= level_reg + ONE;
            2'b01:   level_reg <= level_reg - ONE;
            default: level_reg <= level_reg;
         endcase
         overflow_reg  <= overflow_reg  | wr_err;
         underflow_reg <= underflow_reg | rd_err;
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk_i) begin
      if (!a_rst_i) begin
         assert (!wr_err) else $warning("sync_fifo_flex: write attempted while full");
         assert (!rd_err) else $warning("sync_fifo_flex: read attempted while empty");
      end
      assert (ADDR_WIDTH >= 1) else $error("sync_fifo_flex: ADDR_WIDTH must be >= 1");
      assert (DATA_WIDTH >= 1) else $error("sync_fifo_flex: DATA_WIDTH must be >= 1");
      assert (RAM_STYLE == "auto" || RAM_STYLE == "block" || RAM_STYLE == "distributed" ||
              RAM_STYLE == "registers")
         else $warning("sync_fifo_flex: unrecognised RAM_STYLE");
   end
`endif

endmodule

// File: tb/tb_sync_fifo_flex.sv
// tb_sync_fifo_flex: scoreboard bench for sync_fifo_flex (DEPTH=4, 8-bit), standard or FWFT build.
module tb_sync_fifo_flex;
   localparam int DW    = 8;
   localparam int AW    = 2;
   localparam int DEPTH = 4;

   logic          clk_i       = 1'b0;
   logic          a_rst_i     = 1'b1;
   logic          flush_i     = 1'b0;
   logic          wr_en_i     = 1'b0;
   logic          rd_en_i     = 1'b0;
   logic [DW-1:0] data_i      = '0;
   logic [AW:0]   af_thresh_i = 3'd3;
   logic [AW:0]   ae_thresh_i = 3'd1;
   logic          full_o, almost_full_o, valid_o, empty_o, almost_empty_o;
   logic          overflow_o, underflow_o;
   logic [DW-1:0] data_o;
   logic [AW:0]   level_o;

   int            check_cnt = 0;
   int            err_cnt   = 0;
   int            mdl_level;
   logic [DW-1:0] mdl_data;
   bit            mdl_valid, mdl_ovf, mdl_unf;
   logic [DW-1:0] exp_q [$];

   sync_fifo_flex #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_STYLE("auto")) dut (
      .clk_i(clk_i), .a_rst_i(a_rst_i), .flush_i(flush_i),
      .wr_en_i(wr_en_i), .data_i(data_i), .full_o(full_o), .almost_full_o(almost_full_o),
      .rd_en_i(rd_en_i), .data_o(data_o), .valid_o(valid_o), .empty_o(empty_o),
      .almost_empty_o(almost_empty_o), .af_thresh_i(af_thresh_i), .ae_thresh_i(ae_thresh_i),
      .level_o(level_o), .overflow_o(overflow_o), .underflow_o(underflow_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, required finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic mdl_reset();
      mdl_level = 0;
      mdl_data  = '0;
      mdl_valid = 1'b0;
      mdl_ovf   = 1'b0;
      mdl_unf   = 1'b0;
      exp_q.delete();
   endtask

   task automatic check_state(input string tag);
      $display("%-12s wr=%0d rd=%0d level=%0d valid=%0d data=%02h ovf=%0d unf=%0d",
               tag, wr_en_i, rd_en_i, level_o, valid_o, data_o, overflow_o, underflow_o);
      chk({tag, ".level"}, 32'(level_o),        32'(mdl_level));
      chk({tag, ".full"},  32'(full_o),         32'(mdl_level == DEPTH));
      chk({tag, ".empty"}, 32'(empty_o),        32'(mdl_level == 0));
      chk({tag, ".af"},    32'(almost_full_o),  32'(mdl_level >= int'(af_thresh_i)));
      chk({tag, ".ae"},    32'(almost_empty_o), 32'(mdl_level <= int'(ae_thresh_i)));
      chk({tag, ".valid"}, 32'(valid_o),        32'(mdl_valid));
      chk({tag, ".data"},  32'(data_o),         32'(mdl_data));
      chk({tag, ".ovf"},   32'(overflow_o),     32'(mdl_ovf));
      chk({tag, ".unf"},   32'(underflow_o),    32'(mdl_unf));
   endtask

   task automatic do_cycle(input string tag, input bit wr, input logic [DW-1:0] d, input bit rd);
      bit wacc, racc;
      wacc = wr && (mdl_level < DEPTH);
      racc = rd && (mdl_level > 0);
      wr_en_i = wr;
      data_i  = d;
      rd_en_i = rd;
      if (wacc) exp_q.push_back(d);
      mdl_level = mdl_level + int'(wacc) - int'(racc);
      mdl_ovf   = mdl_ovf | (wr && !wacc);
      mdl_unf   = mdl_unf | (rd && !racc);
`ifdef SYNC_FIFO_FLEX_FWFT_EN
      if (racc) void'(exp_q.pop_front());
`endif
      @(posedge clk_i);
      #1;
`ifdef SYNC_FIFO_FLEX_FWFT_EN
      mdl_valid = (exp_q.size() > 0);
      if (mdl_valid) mdl_data = exp_q[0];
`else
      mdl_valid = racc;
      if (racc) mdl_data = exp_q.pop_front();
`endif
      check_state(tag);
      wr_en_i = 1'b0;
      rd_en_i = 1'b0;
   endtask

   task automatic flush_cycle(input string tag, input bit wr);
      flush_i = 1'b1;
      wr_en_i = wr;
      data_i  = 8'hEE;
      @(posedge clk_i);
      #1;
      mdl_level = 0;
      mdl_valid = 1'b0;
      mdl_ovf   = 1'b0;
      mdl_unf   = 1'b0;
      exp_q.delete();
      check_state(tag);
      flush_i = 1'b0;
      wr_en_i = 1'b0;
   endtask

   initial begin
      logic [DW-1:0] val;
      mdl_reset();
      repeat (2) @(posedge clk_i);
      #1;
      check_state("reset");
      af_thresh_i = 3'd0;
      #1;
      chk("af_thresh0", 32'(almost_full_o), 32'(1));
      af_thresh_i = 3'd3;
      a_rst_i = 1'b0;

      for (int i = 0; i < 5; i++) do_cycle("fill", 1'b1, 8'(17 * (i + 1)), 1'b0);
      for (int i = 0; i < 5; i++) do_cycle("drain", 1'b0, '0, 1'b1);

      flush_cycle("flush", 1'b0);
      for (int i = 0; i < 4; i++) do_cycle("fill", 1'b1, 8'(8'h21 + i), 1'b0);
      do_cycle("full_wr_rd", 1'b1, 8'h66, 1'b1);
      for (int i = 0; i < 3; i++) do_cycle("drain", 1'b0, '0, 1'b1);
      do_cycle("empty_wr_rd", 1'b1, 8'h77, 1'b1);
      do_cycle("drain", 1'b0, '0, 1'b1);

      flush_cycle("flush", 1'b0);
      val = 8'h80;
      for (int r = 0; r < 10; r++) begin
         for (int k = 0; k < 3; k++) begin
            do_cycle("wrap_wr", 1'b1, val, 1'b0);
            val = val + 8'd1;
         end
         for (int k = 0; k < 3; k++) do_cycle("wrap_rd", 1'b0, '0, 1'b1);
      end

      do_cycle("pre_flush", 1'b1, 8'h3C, 1'b0);
      do_cycle("pre_flush", 1'b1, 8'h3D, 1'b0);
      flush_cycle("flush_wr", 1'b1);

      do_cycle("burst", 1'b1, 8'h91, 1'b0);
      do_cycle("burst", 1'b1, 8'h92, 1'b0);
      do_cycle("burst_rd", 1'b0, '0, 1'b1);
      wr_en_i = 1'b1;
      data_i  = 8'h99;
      #2;
      a_rst_i = 1'b1;
      #1;
      mdl_reset();
      check_state("async_rst");
      wr_en_i = 1'b0;
      @(posedge clk_i);
      #1;
      check_state("rst_held");
      a_rst_i = 1'b0;

      do_cycle("wr_a5", 1'b1, 8'hA5, 1'b0);
      do_cycle("wr_b6", 1'b1, 8'hB6, 1'b0);
      do_cycle("pop", 1'b0, '0, 1'b1);
      do_cycle("pop", 1'b0, '0, 1'b1);
      do_cycle("pop", 1'b0, '0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
      $finish;
   end
endmodule
